// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared types and helpers for the countdown timer slice.
//   - tmr_state_e      : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   - prescale_width() : counter width for a given prescale ratio (minimum 1 bit)
//   Optional feature macro used by this slice: AUTO_RELOAD_EN
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } tmr_state_e;

  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Control/status bundle of the countdown timer.
//   master : drives ld, v, start, pause; observes count, busy, done, zero
//   slave  : the timer itself (inverse directions)
//   Signals:
//     ld     load count from v
//     v      preload value (WIDTH)
//     start  begin countdown (honoured in IDLE only)
//     pause  level, freezes a running countdown
//     count  current count (WIDTH)
//     busy   high while running or paused
//     done   one-cycle pulse when the count reaches zero
//     zero   count == 0
//   Optional feature macro used by this slice: AUTO_RELOAD_EN
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  import countdown_timer_pkg::*;

  logic             ld;
  logic [WIDTH-1:0] v;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output ld, v, start, pause,
    input  count, busy, done, zero
  );

  modport slave (
    input  ld, v, start, pause,
    output count, busy, done, zero
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler
//   Free-running divide-by-PRESCALE counter that produces the decrement tick
//   for the countdown timer. Holds its value whenever en is low, so pausing
//   neither loses nor adds a tick.
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset (counter -> 0)
//     clr   in  synchronous clear (counter -> 0), wins over en
//     en    in  advance the counter this cycle
//     tick  out en && counter at terminal value (PRESCALE-1)
//   Optional feature macro used by this slice: AUTO_RELOAD_EN (not used here)
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = prescale_width(PRESCALE);
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // With PRESCALE == 1 the counter stays at 0 == TERM, so every enabled cycle ticks.
  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with start/pause control and prescaled decrement.
//   The count is preloaded via ld/v, started with start, and decremented once
//   every PRESCALE enabled cycles until it reaches zero, at which point a
//   one-cycle done pulse is raised.
//   Ports:
//     clk   in  clock, posedge
//     rst   in  synchronous active-high reset
//     bus   countdown_timer_if.slave (ld, v, start, pause -> count, busy, done, zero)
//   Parameters:
//     WIDTH     count width (>= 2), must match the interface WIDTH
//     PRESCALE  clk cycles per decrement (>= 1)
//   Optional feature macro: AUTO_RELOAD_EN
//     When defined, v is also captured into a reload register on every ld and
//     the timer restarts from it after each DONE (if nonzero), giving a
//     periodic done pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             busy_q, done_q;
  logic             pre_clr, pre_en, tick;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else if (bus.ld) begin
      reload_q <= bus.v;
    end
  end
`endif

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // Next-state logic. A PAUSE state with pause released behaves exactly like
  // RUN for that cycle, so the prescaler resumes on the same edge it leaves
  // PAUSE and the total delay grows by exactly the number of paused cycles.
  always_comb begin
    state_n = state;
    count_n = count_q;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    if (bus.ld) begin
      count_n = bus.v;
      state_n = S_IDLE;
      pre_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (count_q != '0)) begin
            state_n = S_RUN;
            pre_clr = 1'b1;
          end
        end
        S_RUN, S_PAUSE: begin
          if (bus.pause) begin
            state_n = S_PAUSE;
          end else begin
            state_n = S_RUN;
            pre_en  = 1'b1;
            if (tick && (count_q != '0)) begin
              count_n = count_q - 1'b1;
              if (count_q == WIDTH'(1)) begin
                state_n = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
`ifdef AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_n = reload_q;
            state_n = S_RUN;
            pre_clr = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
`else
          state_n = S_IDLE;
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      busy_q  <= (state_n == S_RUN) || (state_n == S_PAUSE);
      done_q  <= (state_n == S_DONE);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed self-checking bench for countdown_timer (WIDTH=8, PRESCALE=4).
//   Inputs change and outputs are sampled just after each falling edge.
//   Optional feature macro honoured: AUTO_RELOAD_EN
module tb_countdown_timer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  countdown_timer_if #(.WIDTH(8)) tif ();

  countdown_timer #(
    .WIDTH    (8),
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the inputs for one clock edge, then drop the one-shot controls.
  task automatic applyStimulus(input logic ldI, input logic [7:0] vI,
                               input logic startI, input logic pauseI);
    tif.ld    = ldI;
    tif.v     = vI;
    tif.start = startI;
    tif.pause = pauseI;
    @(negedge clk);
    tif.ld    = 1'b0;
    tif.start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] c,
                          input logic b, input logic d);
    checkOutput({tag, ".count"}, 32'(tif.count), 32'(c));
    checkOutput({tag, ".busy"},  32'(tif.busy),  32'(b));
    checkOutput({tag, ".done"},  32'(tif.done),  32'(d));
    checkOutput({tag, ".zero"},  32'(tif.zero),  32'(c == 8'd0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    tif.ld    = 1'b0;
    tif.v     = 8'd0;
    tif.start = 1'b0;
    tif.pause = 1'b0;

    // 1. reset, then start with count 0 is ignored
    waitCycles(2);
    checkAll("reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkAll("start_zero", 8'd0, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("start_zero_next", 8'd0, 1'b0, 1'b0);

    // pause in IDLE is ignored
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkAll("pause_idle", 8'd0, 1'b0, 1'b0);
    tif.pause = 1'b0;

    // 2. load 3 and count down; decrements at +4, +8, +12
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    checkAll("load3", 8'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkAll("run3_e0", 8'd3, 1'b1, 1'b0);
    waitCycles(3);
    checkAll("run3_e3", 8'd3, 1'b1, 1'b0);
    waitCycles(1);
    checkAll("run3_e4", 8'd2, 1'b1, 1'b0);
    waitCycles(4);
    checkAll("run3_e8", 8'd1, 1'b1, 1'b0);
    waitCycles(3);
    checkAll("run3_e11", 8'd1, 1'b1, 1'b0);
    waitCycles(1);
    checkAll("run3_e12", 8'd0, 1'b0, 1'b1);
    waitCycles(1);
`ifdef AUTO_RELOAD_EN
    checkAll("run3_e13", 8'd3, 1'b1, 1'b0);
`else
    checkAll("run3_e13", 8'd0, 1'b0, 1'b0);
`endif

    // 3. load 5, pause for 7 cycles after 5 running cycles -> done at +27
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
    checkAll("load5", 8'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    waitCycles(5);
    checkAll("run5_e5", 8'd4, 1'b1, 1'b0);
    tif.pause = 1'b1;
    waitCycles(7);
    checkAll("run5_paused", 8'd4, 1'b1, 1'b0);
    tif.pause = 1'b0;
    waitCycles(14);
    checkAll("run5_e26", 8'd1, 1'b1, 1'b0);
    waitCycles(1);
    checkAll("run5_e27", 8'd0, 1'b0, 1'b1);

    // 4. load 10, start, abort with ld v=2 after 6 cycles
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    waitCycles(6);
    checkAll("run10_e6", 8'd9, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
    checkAll("abort", 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      waitCycles(1);
      checkAll("abort_hold", 8'd2, 1'b0, 1'b0);
    end

    // 5. simultaneous ld and start: ld wins, stays IDLE
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
    checkAll("ld_start", 8'd4, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("ld_start_next", 8'd4, 1'b0, 1'b0);

    // rst mid-countdown returns everything to reset values
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    waitCycles(5);
    checkAll("run4_e5", 8'd3, 1'b1, 1'b0);
    rst = 1'b1;
    waitCycles(1);
    checkAll("mid_reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;

`ifdef AUTO_RELOAD_EN
    // 6. auto reload: done every 9 cycles; ld v=0 (here in DONE) stops it
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    waitCycles(7);
    checkAll("ar_e7", 8'd1, 1'b1, 1'b0);
    waitCycles(1);
    checkAll("ar_e8", 8'd0, 1'b0, 1'b1);
    waitCycles(1);
    checkAll("ar_e9", 8'd2, 1'b1, 1'b0);
    waitCycles(8);
    checkAll("ar_e17", 8'd0, 1'b0, 1'b1);
    waitCycles(8);
    checkAll("ar_e25", 8'd1, 1'b1, 1'b0);
    waitCycles(1);
    checkAll("ar_e26", 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    checkAll("ar_stop", 8'd0, 1'b0, 1'b0);
    waitCycles(12);
    checkAll("ar_stopped", 8'd0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
